// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// cpu_run_ctrl: run/step/halt sequencer issuing a one-cycle CPU clock enable, CPU reset and cycle count.
// Optional macro CPU_STEP_DEBOUNCE_EN: step press accepted after a debounced low instead of a raw edge.
module cpu_run_ctrl #(
    parameter int FAST_DIV        = 256,
    parameter int SLOW_DIV        = 16777216,
    parameter int RST_CYCLES      = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic [1:0]  iMODE,
    input  logic        iSTEP_n,
    input  logic        iMANUAL_RST,
    input  logic        iHLT,
    output logic        oCPU_EN,
    output logic        oCPU_RST_n,
    output logic [31:0] oCYCLES,
    output logic [1:0]  oSTATE
);

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_RUN      = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    localparam logic [1:0] MODE_FAST  = 2'b00;
    localparam logic [1:0] MODE_SLOW  = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;

    localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int TW      = $clog2(MAX_DIV);
    localparam int HW      = $clog2(RST_CYCLES + 1);

    localparam logic [TW-1:0] C_FAST_LAST = TW'(FAST_DIV - 1);
    localparam logic [TW-1:0] C_SLOW_LAST = TW'(SLOW_DIV - 1);
    localparam logic [HW-1:0] C_HOLD_INIT = HW'(RST_CYCLES);
    localparam logic [HW-1:0] C_HOLD_LAST = HW'(1);

    logic [1:0]    mode_s1_q, mode_s2_q;
    logic          step_s1_q, step_s2_q;
    logic          mrst_s1_q, mrst_s2_q;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          en_q, en_d;
    logic [31:0]   cycles_q, cycles_d;

    logic          press;
    logic          mode_chg;
    logic          fire;

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            mode_s1_q <= 2'b00;
            mode_s2_q <= 2'b00;
            step_s1_q <= 1'b1;
            step_s2_q <= 1'b1;
            mrst_s1_q <= 1'b0;
            mrst_s2_q <= 1'b0;
        end else begin
            mode_s1_q <= iMODE;
            mode_s2_q <= mode_s1_q;
            step_s1_q <= iSTEP_n;
            step_s2_q <= step_s1_q;
            mrst_s1_q <= iMANUAL_RST;
            mrst_s2_q <= mrst_s1_q;
        end
    end

    // Clearing on the edge where the synchronised mode takes its new value.
    assign mode_chg = (mode_s1_q != mode_s2_q);

`ifdef CPU_STEP_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] C_DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           db_lvl_q, db_lvl_d;

    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        press    = 1'b0;
        if (step_s2_q != db_lvl_q) begin
            if (db_cnt_q == C_DB_LAST) begin
                db_lvl_d = step_s2_q;
                press    = ~step_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b1;
        end else begin
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
        end
    end
`else
    logic step_prev_q;

    assign press = step_prev_q & ~step_s2_q;

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            step_prev_q <= 1'b1;
        end else begin
            step_prev_q <= step_s2_q;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        tick_d   = tick_q;
        en_d     = 1'b0;
        cycles_d = cycles_q;
        fire     = 1'b0;
        case (state_q)
            ST_RST_HOLD: begin
                tick_d = '0;
                if (mrst_s2_q) begin
                    hold_d   = C_HOLD_INIT;
                    cycles_d = '0;
                end else if (hold_q == C_HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (mrst_s2_q) begin
                    state_d  = ST_RST_HOLD;
                    hold_d   = C_HOLD_INIT;
                    cycles_d = '0;
                    tick_d   = '0;
                end else begin
                    if (mode_chg) begin
                        tick_d = '0;
                    end else if (mode_s2_q == MODE_FAST) begin
                        fire   = (tick_q == C_FAST_LAST);
                        tick_d = fire ? '0 : tick_q + 1'b1;
                    end else if (mode_s2_q == MODE_SLOW) begin
                        fire   = (tick_q == C_SLOW_LAST);
                        tick_d = fire ? '0 : tick_q + 1'b1;
                    end
                    if (mode_s2_q == MODE_STEP) begin
                        fire = press;
                    end
                    // Halt suppresses any enable due on the same cycle.
                    if (iHLT) begin
                        state_d = ST_HALTED;
                    end else if (fire) begin
                        en_d     = 1'b1;
                        cycles_d = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
                    end
                end
            end
            ST_HALTED: begin
                tick_d = '0;
                if (mrst_s2_q) begin
                    state_d  = ST_RST_HOLD;
                    hold_d   = C_HOLD_INIT;
                    cycles_d = '0;
                end
            end
            default: begin
                state_d = ST_RST_HOLD;
                hold_d  = C_HOLD_INIT;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q  <= ST_RST_HOLD;
            hold_q   <= C_HOLD_INIT;
            tick_q   <= '0;
            en_q     <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            tick_q   <= tick_d;
            en_q     <= en_d;
            cycles_q <= cycles_d;
        end
    end

    assign oCPU_EN    = en_q;
    assign oCPU_RST_n = (state_q != ST_RST_HOLD);
    assign oCYCLES    = cycles_q;
    assign oSTATE     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// tb_cpu_run_ctrl: directed self-checking bench for cpu_run_ctrl (FAST 4, SLOW 16, hold 8, debounce 4).
module tb_cpu_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic        step_n;
    logic        mrst;
    logic        hlt;
    logic        en;
    logic        cpu_rst_n;
    logic [31:0] cycles;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    bit en_during_rst = 0;
    int n;
    logic [31:0] exp_cyc;

    cpu_run_ctrl #(
        .FAST_DIV(4),
        .SLOW_DIV(16),
        .RST_CYCLES(8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .iCLK(clk),
        .iRST_n(rst_n),
        .iMODE(mode),
        .iSTEP_n(step_n),
        .iMANUAL_RST(mrst),
        .iHLT(hlt),
        .oCPU_EN(en),
        .oCPU_RST_n(cpu_rst_n),
        .oCYCLES(cycles),
        .oSTATE(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            if (en === 1'b1) en_cnt++;
            if (en === 1'b1 && cpu_rst_n !== 1'b1) en_during_rst = 1'b1;
        end
    endtask

    task automatic wait_en(output int cnt);
        cnt = 0;
        do begin
            cyc(1);
            cnt++;
        end while (en !== 1'b1 && cnt < 100);
    endtask

    task automatic wait_rst_rise(output int cnt);
        cnt = 0;
        do begin
            cyc(1);
            cnt++;
        end while (cpu_rst_n !== 1'b1 && cnt < 100);
    endtask

    task automatic press(input int lo, input int hi);
        step_n = 1'b0;
        cyc(lo);
        step_n = 1'b1;
        cyc(hi);
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'b00; step_n = 1'b1; mrst = 1'b0; hlt = 1'b0;

        // 1: reset, hold release, FAST cadence
        cyc(3);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("rst_en", {31'd0, en}, 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        rst_n = 1'b1;
        wait_rst_rise(n);
        chk("hold_latency", n, 32'd8);
        chk("run_state", {30'd0, state}, 32'd1);
        wait_en(n);
        chk("first_en_latency", n, 32'd4);
        chk("cycles_after_1", cycles, 32'd1);
        for (int p = 2; p <= 5; p++) begin
            wait_en(n);
            chk("fast_period", n, 32'd4);
        end
        chk("cycles_after_5", cycles, 32'd5);
        cyc(1);
        chk("en_one_cycle", {31'd0, en}, 32'd0);

        // 6: FAST -> SLOW mid-count
        mode = 2'b01;
        wait_en(n);
        chk("slow_after_change", n, 32'd18);
        wait_en(n);
        chk("slow_period", n, 32'd16);
        exp_cyc = 32'd7;
        chk("cycles_after_slow", cycles, exp_cyc);

        // 2: STEP presses
        mode = 2'b10;
        cyc(4);
        en_cnt = 0;
        press(10, 10);
        press(10, 10);
        press(10, 10);
        chk("step_enables", en_cnt, 32'd3);
        exp_cyc = exp_cyc + 32'd3;
        chk("step_cycles", cycles, exp_cyc);
        en_cnt = 0;
        press(2, 10);
`ifdef CPU_STEP_DEBOUNCE_EN
        chk("glitch_enables", en_cnt, 32'd0);
`else
        chk("glitch_enables", en_cnt, 32'd1);
        exp_cyc = exp_cyc + 32'd1;
`endif
        chk("glitch_cycles", cycles, exp_cyc);

        // 3: halt on the cycle a tick is due
        mode = 2'b00;
        cyc(4);
        wait_en(n);
        chk("fast_resume_seen", {31'd0, en}, 32'd1);
        exp_cyc = exp_cyc + 32'd1;
        cyc(3);
        hlt = 1'b1;
        cyc(1);
        chk("halt_no_en", {31'd0, en}, 32'd0);
        chk("halt_state", {30'd0, state}, 32'd2);
        chk("halt_cycles", cycles, exp_cyc);
        hlt = 1'b0;
        en_cnt = 0;
        mode = 2'b01;
        cyc(20);
        mode = 2'b10;
        cyc(3);
        press(8, 8);
        chk("halted_enables", en_cnt, 32'd0);
        chk("halted_state", {30'd0, state}, 32'd2);
        chk("halted_cycles", cycles, exp_cyc);

        // Manual reset from HALTED; press was not queued
        mrst = 1'b1;
        cyc(5);
        chk("mrst_halted_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        mrst = 1'b0;
        wait_rst_rise(n);
        chk("mrst_halted_run", {30'd0, state}, 32'd1);
        en_cnt = 0;
        cyc(6);
        chk("step_not_queued", en_cnt, 32'd0);
        chk("mrst_halted_cycles", cycles, 32'd0);
        mode = 2'b00;
        wait_en(n);
        chk("post_mrst_cycles", cycles, 32'd1);

        // 4: manual reset mid-run
        mrst = 1'b1;
        cyc(2);
        chk("mrst_sync_delay", {31'd0, cpu_rst_n}, 32'd1);
        cyc(1);
        chk("mrst_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("mrst_cycles", cycles, 32'd0);
        chk("mrst_state", {30'd0, state}, 32'd0);
        cyc(2);
        mrst = 1'b0;
        wait_rst_rise(n);
        chk("mrst_release_latency", n, 32'd10);
        wait_en(n);
        chk("mrst_first_en", n, 32'd4);
        chk("mrst_first_cycles", cycles, 32'd1);

        // 5: saturation
        force dut.cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycles_q;
        wait_en(n);
        chk("sat_first", cycles, 32'hFFFF_FFFF);
        wait_en(n);
        wait_en(n);
        chk("sat_en_pulses", {31'd0, en}, 32'd1);
        chk("sat_hold", cycles, 32'hFFFF_FFFF);

        chk("no_en_in_reset", {31'd0, en_during_rst}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
